serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand width in bits; legal range is WIDTH >= 1.
REQ-002 Parameter HAS_BIN, default 0; when it is 1, the borrow-in port bin is honoured.
REQ-003 Parameter CHUNK, default 8, sets the bits processed per cycle; legal range is 1 <= CHUNK <= WIDTH.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-007 Port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-008 Port a, input, WIDTH bits: minuend, unsigned.
REQ-009 Port b, input, WIDTH bits: subtrahend, unsigned.
REQ-010 Port bin, input, 1 bit: borrow-in; it is ignored when HAS_BIN=0.
REQ-011 Port out_valid, output, 1 bit: the result on diff is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port diff, output, WIDTH+1 bits: diff[WIDTH-1:0] is (a - b - bin) mod 2^WIDTH, and diff[WIDTH] is the borrow-out.

Function
REQ-014 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 in_ready SHALL equal (state == IDLE); no operand pair is accepted in BUSY or DONE.
REQ-016 IDLE SHALL behave as follows:
- On in_valid & in_ready, capture a and b.
- Set the borrow register to (bin & HAS_BIN).
- Set the chunk index to 0.
- Go to BUSY.
REQ-017 Each BUSY cycle SHALL process chunk idx, i.e. bits [idx*CHUNK +: CHUNK]:
- Compute chunk result = a_chunk - b_chunk - borrow.
- Store the result into the diff register.
- Update borrow.
- Increment idx.
REQ-018 Chunk count N SHALL be ceil(WIDTH/CHUNK); the last chunk, when WIDTH mod CHUNK != 0, SHALL be that many bits wide, and borrow SHALL be taken at bit WIDTH, not at the chunk boundary.
REQ-019 After chunk N-1 the block SHALL move to DONE, set diff[WIDTH] to the final borrow and assert out_valid.
REQ-020 Latency SHALL be exactly N cycles: an accept edge at cycle t gives out_valid=1 from cycle t+N.
REQ-021 In DONE, out_valid and diff SHALL hold stable until out_valid & out_ready; on that edge the block SHALL return to IDLE with out_valid=0.
REQ-022 If in_valid is asserted while in DONE and out_ready=1, that request SHALL NOT be accepted in the same cycle; acceptance occurs in the following IDLE cycle.
REQ-023 diff[WIDTH-1:0] SHALL be undefined-free: bits not yet computed SHALL read 0 while in BUSY.
REQ-024 Every operand value SHALL produce a mod-2^WIDTH result with a correct borrow, including a=b, a=0, and all-ones operands.

Reset
REQ-025 While rst_n=0, the block SHALL force state=IDLE, out_valid=0, diff=0, borrow=0 and idx=0, independent of clk.
REQ-026 Reset asserted in BUSY or DONE SHALL abandon the operation without any output handshake; in_ready=1 follows immediately from IDLE.
REQ-027 The first accept after rst_n deasserts SHALL occur no earlier than the first rising clk edge with rst_n=1.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold:
- The state enum (IDLE, BUSY, DONE).
- A function num_chunks(WIDTH, CHUNK) returning ceil(WIDTH/CHUNK).
REQ-029 One combinational sub-module, sub_chunk, SHALL be parameterized by CHUNK and perform a CHUNK-bit subtract with borrow-in and borrow-out.
REQ-030 An elaboration-time check SHALL reject illegal WIDTH/CHUNK combinations.

Verification (WIDTH=35, CHUNK=8, N=5 unless stated)
REQ-031 a=10, b=3 -> diff=7, diff[35]=0, out_valid exactly 5 cycles after the accept edge.
REQ-032 a=0, b=1 -> diff[34:0]=0x7_FFFF_FFFF, diff[35]=1; a=0x100, b=0x1 -> diff=0xFF (borrow crosses the chunk boundary).
REQ-033 HAS_BIN=1, a=5, b=5, bin=1 -> diff[34:0]=0x7_FFFF_FFFF, diff[35]=1; the same stimulus with HAS_BIN=0 -> diff=0.
REQ-034 Backpressure scenario:
- Stimulus: out_ready held low for 10 cycles in DONE while in_valid=1 with new operands.
- Required: diff stable and in_ready=0 throughout; the second pair is accepted only after the out handshake plus one IDLE cycle.
REQ-035 rst_n pulsed low during BUSY (idx=2) -> out_valid never asserts; in_ready=1 during reset; the next op a=7, b=2 gives diff=5.
REQ-036 WIDTH=32, CHUNK=32 (N=1) back-to-back random ops -> results match the reference model (a - b) mod 2^33.

Source files
------------

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and helpers for the chunked serial subtractor.
//               - state_t    : controller states (IDLE, BUSY, DONE)
//               - num_chunks : ceil(width / chunk), the number of BUSY cycles
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module      : sub_chunk
// Description : Combinational CHUNK-bit subtractor with borrow in/out.
//               o_diff = (i_a - i_b - i_bin) mod 2^CHUNK
//               o_bout = 1 when the true difference is negative
// Ports       : i_a, i_b [CHUNK-1:0]  operands
//               i_bin                 borrow-in
//               o_diff [CHUNK-1:0]    difference
//               o_bout                borrow-out
// Revision    : 1.0 - initial release
// ============================================================================
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_bin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_bout
);

    // One extra bit of headroom: the extended result lies in
    // [-2^CHUNK, 2^CHUNK-1], so its top bit is exactly the borrow.
    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
    assign o_diff = w_full[CHUNK-1:0];
    assign o_bout = w_full[CHUNK];

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle unsigned subtractor. An accepted operand pair is
//               processed CHUNK bits per cycle over ceil(WIDTH/CHUNK) cycles;
//               the result is then held with valid/ready handshaking.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               in_valid/in_ready   operand handshake (ready only in IDLE)
//               a, b [WIDTH-1:0]    minuend, subtrahend (unsigned)
//               bin                 borrow-in, used only when HAS_BIN=1
//               out_valid/out_ready result handshake
//               diff [WIDTH:0]      {borrow-out, (a - b - bin) mod 2^WIDTH}
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int HAS_BIN = 0,
    parameter int CHUNK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int c_num_chunks = num_chunks(WIDTH, CHUNK);
    localparam int c_pad_width  = c_num_chunks * CHUNK;
    localparam int c_idx_width  = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || HAS_BIN < 0 || HAS_BIN > 1) begin : g_param_check
            $error("serial_subtractor: illegal parameters WIDTH=%0d CHUNK=%0d HAS_BIN=%0d",
                   WIDTH, CHUNK, HAS_BIN);
        end
    endgenerate

    state_t                   r_state;
    logic [c_pad_width-1:0]   r_a;
    logic [c_pad_width-1:0]   r_b;
    logic                     r_borrow;
    logic [c_idx_width-1:0]   r_idx;
    logic [WIDTH-1:0]         r_diff;
    logic                     r_bout;
    logic                     r_out_valid;

    logic [CHUNK-1:0]         w_chunk_diff;
    logic                     w_chunk_bout;
    logic                     w_bin_eff;
    logic                     w_last;
    logic [31:0]              w_shamt;
    logic [WIDTH-1:0]         w_ins;

    // Operands are zero-padded to a whole number of chunks and shifted right
    // each BUSY cycle, so the active chunk is always in the low bits.
    // For a short final chunk the zero padding makes the chunk's borrow-out
    // equal to the borrow at bit WIDTH: a negative result sign-fills the pad
    // bits and sets the borrow, a non-negative one leaves both at zero.
    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .i_a    (r_a[CHUNK-1:0]),
        .i_b    (r_b[CHUNK-1:0]),
        .i_bin  (r_borrow),
        .o_diff (w_chunk_diff),
        .o_bout (w_chunk_bout)
    );

    assign w_bin_eff = (HAS_BIN != 0) & bin;
    assign w_last    = (r_idx == c_idx_width'(c_num_chunks - 1));
    assign w_shamt   = 32'(r_idx) * 32'(CHUNK);

    // Chunk result placed at its final bit position; bits shifted past WIDTH
    // (padding of a short last chunk) fall off. Uncomputed bits stay zero
    // because r_diff is cleared on accept and only ORed into.
    assign w_ins = WIDTH'(w_chunk_diff) << w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_idx       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= c_pad_width'(a);
                        r_b      <= c_pad_width'(b);
                        r_borrow <= w_bin_eff;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_bout   <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_a      <= r_a >> CHUNK;
                    r_b      <= r_b >> CHUNK;
                    r_borrow <= w_chunk_bout;
                    r_diff   <= r_diff | w_ins;
                    r_idx    <= r_idx + c_idx_width'(1);
                    if (w_last) begin
                        r_idx       <= '0;
                        r_bout      <= w_chunk_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here (not accepting directly) makes a
                    // new pair wait for one IDLE cycle after the handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = {r_bout, r_diff};

endmodule
`default_nettype wire
